// File: rtl/simd_pipe_pkg.sv
// Shared types for the skid register: FSM state encoding, occupancy width and
// a helper that maps a state to its held-beat count.
// Ports: none (package).
package simd_pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_e st);
        case (st)
            ST_BUSY: return OCC_W'(1);
            ST_FULL: return OCC_W'(2);
            default: return OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/skid_register_if.sv
// Valid/ready stream of N-bit beats, one instance per side of the skid register.
// Ports: valid/data driven by the master, ready driven by the slave.
// Modports: master (producer side), slave (consumer side).
interface skid_register_if #(
    parameter int N = 32
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/skid_register.sv
// Two-slot skid register: registered in_ready, one-cycle latency, order preserved.
// Latency 1 cycle; in_ready is a flop so it never depends combinationally on out_ready.
// Backpressure: the skid slot absorbs the beat in flight while out_ready is low.
// Ports: clk, rst (async active-low), [flush when SKID_FLUSH_EN is defined],
//        in_if (slave stream), out_if (master stream), occupancy (0/1/2 held beats).
// Optional feature: define SKID_FLUSH_EN to add the synchronous flush input.
module skid_register
    import simd_pipe_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SKID_FLUSH_EN
    input  logic              flush,
`endif
    skid_register_if.slave    in_if,
    skid_register_if.master   out_if,
    output logic [OCC_W-1:0]  occupancy
);

    skid_state_e  r_state;
    skid_state_e  w_state_nxt;
    logic [N-1:0] r_main;
    logic [N-1:0] r_skid;
    logic         r_in_rdy;

    logic w_flush;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main;
    logic w_main_from_skid;
    logic w_load_skid;

`ifdef SKID_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_in_xfer  = in_if.valid & r_in_rdy;
    assign w_out_xfer = (r_state != ST_EMPTY) & out_if.ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_in_xfer) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the output side can move.
                if (w_out_xfer) begin
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_BUSY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush wins over every transition and drops any simultaneous input beat.
        if (w_flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_EMPTY;
            r_main   <= '0;
            r_skid   <= '0;
            r_in_rdy <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Look-ahead on the next state keeps in_ready registered yet exact.
            r_in_rdy <= (w_state_nxt != ST_FULL);
            if (w_load_main) r_main <= w_main_from_skid ? r_skid : in_if.data;
            if (w_load_skid) r_skid <= in_if.data;
        end
    end

    assign in_if.ready  = r_in_rdy;
    assign out_if.valid = (r_state != ST_EMPTY);
    assign out_if.data  = r_main;   // held at last value while EMPTY
    assign occupancy    = occ_of(r_state);

endmodule

// File: tb/tb_skid_register.sv
// Bench for skid_register: queue model checked every cycle plus directed
// literal expectations for reset, streaming, stall, drain, flush and random traffic.
module tb_skid_register;
    import simd_pipe_pkg::*;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [OCC_W-1:0] occupancy;

    skid_register_if #(.N(32)) in_if ();
    skid_register_if #(.N(32)) out_if ();

    skid_register #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SKID_FLUSH_EN
        .flush     (flush),
`endif
        .in_if     (in_if),
        .out_if    (out_if),
        .occupancy (occupancy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit seen_dead = 1'b0;

    // Behavioural model: a queue of held beats, at most two deep.
    logic [31:0] mq[$];
    bit          m_in_rdy;
    bit          m_in_acc;
    bit          m_out_acc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update on every edge (and immediately on reset assertion).
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_in_rdy = 1'b0;
        end else begin
            m_in_acc  = in_if.valid && m_in_rdy;
            m_out_acc = out_if.ready && (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_acc) void'(mq.pop_front());
                if (m_in_acc)  mq.push_back(in_if.data);
            end
            m_in_rdy = (mq.size() < 2);
        end
    end

    // Compare process: DUT against model away from the active edge.
    initial forever begin
        @(negedge clk);
        check("mdl_out_valid", {31'd0, out_if.valid}, {31'd0, mq.size() > 0});
        check("mdl_occupancy", {30'd0, occupancy}, mq.size());
        check("mdl_in_ready",  {31'd0, in_if.ready}, {31'd0, m_in_rdy});
        check("in_ready_while_full", {31'd0, in_if.ready && occupancy == 2'd2}, 32'd0);
        if (mq.size() > 0) check("mdl_out_data", out_if.data, mq[0]);
        if (out_if.valid && out_if.data == 32'hDEADBEEF) seen_dead = 1'b1;
    end

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;

        // Reset: outputs forced without any clock edge.
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
        check("rst_occupancy", {30'd0, occupancy}, 32'd0);
        check("rst_in_ready",  {31'd0, in_if.ready}, 32'd0);
        tick();
        tick();
        rst         = 1'b1;
        in_if.valid = 1'b1;
        in_if.data  = 32'h00000011;
        check("release_in_ready_pre", {31'd0, in_if.ready}, 32'd0);
        tick();
        // First edge after release raises in_ready but takes no beat.
        check("release_in_ready_post", {31'd0, in_if.ready}, 32'd1);
        check("release_no_accept", {30'd0, occupancy}, 32'd0);
        in_if.valid = 1'b0;

        // Streaming with downstream always ready.
        out_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_if.valid = 1'b1;
            in_if.data  = i;
            tick();
            check("stream_data", out_if.data, i);
            check("stream_occ", {30'd0, occupancy}, 32'd1);
        end
        in_if.valid = 1'b0;
        tick();
        check("drain_occ", {30'd0, occupancy}, 32'd0);
        check("drain_valid", {31'd0, out_if.valid}, 32'd0);

        // Stall: fill both slots, then release.
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 32'hA5A5A5A5;
        tick();
        in_if.data = 32'h5A5A5A5A;
        tick();
        in_if.valid = 1'b0;
        check("stall_occ", {30'd0, occupancy}, 32'd2);
        check("stall_in_ready", {31'd0, in_if.ready}, 32'd0);
        check("stall_data", out_if.data, 32'hA5A5A5A5);
        tick();
        check("stall_hold_data", out_if.data, 32'hA5A5A5A5);
        out_if.ready = 1'b1;
        tick();
        check("release_second", out_if.data, 32'h5A5A5A5A);
        check("release_occ", {30'd0, occupancy}, 32'd1);
        check("release_in_ready", {31'd0, in_if.ready}, 32'd1);
        tick();
        check("release_empty", {30'd0, occupancy}, 32'd0);

        // Reset mid-FULL discards both beats with no clock edge needed.
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 32'h00001234;
        tick();
        in_if.data = 32'h00005678;
        tick();
        in_if.valid = 1'b0;
        check("full_before_rst", {30'd0, occupancy}, 32'd2);
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_if.valid}, 32'd0);
        check("midrst_occupancy", {30'd0, occupancy}, 32'd0);
        check("midrst_in_ready", {31'd0, in_if.ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_in_ready_after", {31'd0, in_if.ready}, 32'd1);
        check("midrst_discarded", {30'd0, occupancy}, 32'd0);

`ifdef SKID_FLUSH_EN
        // Flush from FULL with a beat offered, then from BUSY with a beat accepted.
        in_if.valid = 1'b1;
        in_if.data  = 32'hC0DE0001;
        tick();
        in_if.data = 32'hC0DE0002;
        tick();
        in_if.data = 32'hDEADBEEF;
        flush      = 1'b1;
        tick();
        flush       = 1'b0;
        in_if.valid = 1'b0;
        check("flush_full_occ", {30'd0, occupancy}, 32'd0);
        check("flush_full_in_ready", {31'd0, in_if.ready}, 32'd1);
        in_if.valid = 1'b1;
        in_if.data  = 32'h0BAD0001;
        tick();
        in_if.data = 32'hDEADBEEF;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        check("flush_busy_occ", {30'd0, occupancy}, 32'd0);
        in_if.data = 32'h00000077;
        tick();
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        check("post_flush_data", out_if.data, 32'h00000077);
        tick();
        check("no_deadbeef", {31'd0, seen_dead}, 32'd0);
        out_if.ready = 1'b0;
`endif

        // Random valid/ready traffic; the model compare covers order and loss.
        for (int c = 0; c < 10000; c++) begin
            in_if.valid  = ($urandom_range(0, 2) != 0);
            in_if.data   = $urandom;
            out_if.ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        tick();
        tick();
        tick();
        check("random_drained", {30'd0, occupancy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
